// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, default
// frame geometry, and a counter-width helper.
package uart_rx_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;
    localparam state_t ST_BREAK  = 3'd5;

    // Width that can hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop metastability synchronizer for the serial input; both stages reset
// to the idle-high line level so reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    assign dout = sync_reg[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start/data/parity/stop framing with break hold.
// Optional input synchronizer is enabled by defining UART_RX_SYNC_EN.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baudTick,
    input  logic                 rx,
    output logic [DATA_BITS:0]   dataParityOut,
    output logic                 ready,
    output logic                 frameError
);

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx),
        .dout (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    state_t              state_reg, state_next;
    logic [TW-1:0]       tick_reg, tick_next;
    logic [BW-1:0]       bit_reg, bit_next;
    logic [DATA_BITS:0]  shift_reg, shift_next;
    logic [DATA_BITS:0]  out_reg, out_next;
    logic                ready_reg, ready_next;
    logic                ferr_reg, ferr_next;
    logic                data_capture;
    logic                parity_capture;

    // Each shift bit loads only on the sampling tick addressed to it.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            assign shift_next[gi] = (data_capture && (bit_reg == BW'(gi))) ? rx_s : shift_reg[gi];
        end
    endgenerate
    assign shift_next[DATA_BITS] = parity_capture ? rx_s : shift_reg[DATA_BITS];

    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg;
        bit_next       = bit_reg;
        out_next       = out_reg;
        ready_next     = 1'b0;
        ferr_next      = 1'b0;
        data_capture   = 1'b0;
        parity_capture = 1'b0;

        if (baudTick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_next = ST_START;
                        tick_next  = '0;
                    end
                end
                ST_START: begin
                    // Half a bit after the falling edge: confirm a real start bit.
                    if (tick_reg == TICK_HALF) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next    = '0;
                        data_capture = 1'b1;
                        if (bit_reg == BIT_LAST) begin
                            bit_next   = '0;
                            state_next = ST_PARITY;
                        end else begin
                            bit_next = bit_reg + BW'(1);
                        end
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next      = '0;
                        parity_capture = 1'b1;
                        state_next     = ST_STOP;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        if (rx_s) begin
                            out_next   = shift_reg;
                            ready_next = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = ST_BREAK;
                        end
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    tick_next  = '0;
                    bit_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            out_reg   <= '0;
            ready_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            out_reg   <= out_next;
            ready_reg <= ready_next;
            ferr_reg  <= ferr_next;
        end
    end

    assign dataParityOut = out_reg;
    assign ready         = ready_reg;
    assign frameError    = ferr_reg;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: directed frames push expected
// outputs; a negedge monitor pops and compares on every ready/frameError pulse.
module tb_uart_rx_deserializer;

    localparam int OS       = 16;
    localparam int NB       = 8;
    localparam int FRAME_T  = 11 * OS;
    localparam int STOP_IDX = 10 * OS + OS / 2;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    typedef struct {
        bit         is_err;
        logic [8:0] val;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       baudTick;
    logic       rx;
    logic [8:0] dataParityOut;
    logic       ready;
    logic       frameError;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [8:0] last_good;
    int         total;
    int         bad;
    int         cyc;

    uart_rx_deserializer #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (NB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baudTick      (baudTick),
        .rx            (rx),
        .dataParityOut (dataParityOut),
        .ready         (ready),
        .frameError    (frameError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready || frameError) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: ready=%0b frameError=%0b data=%h, required no output",
                         ready, frameError, dataParityOut);
            end else begin
                mon_e = exp_q.pop_front();
                total++;
                if (ready !== !mon_e.is_err || frameError !== mon_e.is_err) begin
                    bad++;
                    $display("FAIL pulse_kind: ready=%0b frameError=%0b, required ready=%0b frameError=%0b",
                             ready, frameError, !mon_e.is_err, mon_e.is_err);
                end
                total++;
                if (dataParityOut !== mon_e.val) begin
                    bad++;
                    $display("FAIL data: got %h, required %h", dataParityOut, mon_e.val);
                end
                if (mon_e.cyc >= 0) begin
                    total++;
                    if (cyc !== mon_e.cyc) begin
                        bad++;
                        $display("FAIL latency: pulse at cycle %0d, required cycle %0d", cyc, mon_e.cyc);
                    end
                end
                $display("out: ready=%0b frameError=%0b data=%h cycle=%0d", ready, frameError, dataParityOut, cyc);
            end
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One baud tick with the given line level, followed by gap idle clocks.
    task automatic tk(input logic r, input int gap);
        rx       = r;
        baudTick = 1'b1;
        @(posedge clk);
        #1;
        baudTick = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_ticks(input logic r, input int n);
        for (int i = 0; i < n; i++) tk(r, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int gap, input int n_ticks);
        exp_t e;
        logic r;
        int   b;
        for (int i = 0; i < n_ticks; i++) begin
            b = i / OS;
            if (b == 0)       r = 1'b0;
            else if (b <= NB) r = d[b-1];
            else if (b == 9)  r = p;
            else              r = stop;
            if (i == STOP_IDX) begin
                e.is_err = !stop;
                e.val    = stop ? {p, d} : last_good;
                e.cyc    = (gap == 0) ? cyc + 1 + SYNC_DLY : -1;
                exp_q.push_back(e);
                if (stop) last_good = {p, d};
                $display("send: data=%h parity=%0b stop=%0b gap=%0d", d, p, stop, gap);
            end
            tk(r, gap);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        last_good = 9'h000;
        rst       = 1'b0;
        rx        = 1'b1;
        baudTick  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", dataParityOut, 9'h000);
        check("reset_ready", {8'h00, ready}, 9'h000);
        check("reset_ferr", {8'h00, frameError}, 9'h000);
        rst = 1'b1;
        idle_ticks(1'b1, 4);

        send_frame(8'hA5, 1'b1, 1'b1, 0, FRAME_T);
        idle_ticks(1'b1, 5);

        // Short low glitch must be rejected at mid-start.
        idle_ticks(1'b0, 4);
        idle_ticks(1'b1, 20);
        send_frame(8'h5A, 1'b0, 1'b1, 0, FRAME_T);
        idle_ticks(1'b1, 3);

        // Framing error, line held low (break), then one high tick and a new frame.
        send_frame(8'h3C, 1'b0, 1'b0, 0, FRAME_T);
        idle_ticks(1'b0, 20);
        idle_ticks(1'b1, 1);
        send_frame(8'h66, 1'b1, 1'b1, 0, FRAME_T);
        idle_ticks(1'b1, 3);

        // Reset in the middle of the data bits.
        send_frame(8'h9E, 1'b0, 1'b1, 0, 60);
        rst = 1'b0;
        #1;
        check("midreset_data", dataParityOut, 9'h000);
        check("midreset_ready", {8'h00, ready}, 9'h000);
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b1;
        last_good = 9'h000;
        idle_ticks(1'b1, 20);
        send_frame(8'h9E, 1'b0, 1'b1, 0, FRAME_T);

        // Back-to-back frames with no idle gap.
        send_frame(8'h01, 1'b0, 1'b1, 0, FRAME_T);
        send_frame(8'hFF, 1'b1, 1'b1, 0, FRAME_T);
        idle_ticks(1'b1, 3);

        // Sparse baud ticks: state must freeze between ticks.
        send_frame(8'hC3, 1'b1, 1'b1, 2, FRAME_T);
        idle_ticks(1'b1, 40);

        check("queue_empty", 9'(exp_q.size()), 9'h000);
        check("final_data", dataParityOut, 9'h1C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
